// File: rtl/exe_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// exe_muldiv_pkg
// Shared definitions for the iterative multiply/divide execution unit:
//   - DEFAULT_WIDTH : default operand/result width (also the iteration count)
//   - CMD_*         : EXE_cmd codes seen by the unit (only MUL and DIVU act)
//   - state_t       : controller state encoding (IDLE, BUSY, DONE)
//   - isMulDivCmd   : helper that recognises the two commands the unit runs
// ---------------------------------------------------------------------------
package exe_muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [3:0] CMD_ADD  = 4'b0000;
   localparam logic [3:0] CMD_MUL  = 4'b1100;
   localparam logic [3:0] CMD_DIVU = 4'b1101;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   // True for the commands this unit executes; everything else is left to
   // the ordinary single-cycle ALU and never stalls the pipeline.
   function automatic logic isMulDivCmd(input logic [3:0] cmd);
      return (cmd == CMD_MUL) || (cmd == CMD_DIVU);
   endfunction

endpackage

// File: rtl/exe_muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of either an unsigned shift-add multiply or an
// unsigned restoring shift-subtract divide.
// Ports:
//   isDiv_i    : 1 = divide step, 0 = multiply step
//   opA_i/_o   : MUL: multiplicand (shifts left); DIVU: dividend bits still to
//                be consumed at the top, quotient bits entering at the bottom
//   opB_i/_o   : MUL: multiplier (shifts right); DIVU: divisor (unchanged)
//   acc_i/_o   : MUL: running low product; DIVU: partial remainder
// ---------------------------------------------------------------------------
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             isDiv_i,
   input  logic [WIDTH-1:0] opA_i,
   input  logic [WIDTH-1:0] opB_i,
   input  logic [WIDTH-1:0] acc_i,
   output logic [WIDTH-1:0] opA_o,
   output logic [WIDTH-1:0] opB_o,
   output logic [WIDTH-1:0] acc_o
);

   logic [WIDTH:0]   remShifted;
   logic [WIDTH-1:0] remDiffLow;
   logic             remGeDivisor;

   // The shifted remainder needs one extra bit so the compare against the
   // divisor is exact. When the compare succeeds the true difference is below
   // the divisor, so the low WIDTH bits of the subtraction are the whole
   // answer. A zero divisor always "fits", giving an all-ones quotient.
   always_comb begin
      remShifted   = {acc_i, opA_i[WIDTH-1]};
      remGeDivisor = (remShifted >= {1'b0, opB_i});
      remDiffLow   = remShifted[WIDTH-1:0] - opB_i;
   end

   // Select the multiply or divide update. The multiply keeps only the low
   // WIDTH bits of the product, so bits shifted out of the multiplicand are
   // simply lost.
   always_comb begin
      opA_o = opA_i;
      opB_o = opB_i;
      acc_o = acc_i;
      if (isDiv_i) begin
         opA_o = {opA_i[WIDTH-2:0], remGeDivisor};
         opB_o = opB_i;
         acc_o = remGeDivisor ? remDiffLow : remShifted[WIDTH-1:0];
      end else begin
         opA_o = {opA_i[WIDTH-2:0], 1'b0};
         opB_o = {1'b0, opB_i[WIDTH-1:1]};
         acc_o = opB_i[0] ? (acc_i + opA_i) : acc_i;
      end
   end

endmodule

// File: rtl/exe_muldiv.sv
// ---------------------------------------------------------------------------
// exe_muldiv
// Iterative unsigned multiply (MUL, low WIDTH bits) and divide (DIVU,
// quotient) unit for the EXE stage. It stalls the front of the pipeline while
// it runs WIDTH iterations, then pulses done for one cycle with the result.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   flush      : abort the running operation (branch taken downstream)
//   EXE_cmd    : command from the ID/EX register
//   Val1, Val2 : multiplicand/dividend and multiplier/divisor
//   dest_in    : destination register of the instruction in EXE
//   WB_en_in   : write-back enable of the instruction in EXE
//   freeze     : stall request for PC, IF/ID and ID/EX
//   done       : one-cycle result-valid pulse
//   result     : low product or quotient (holds between operations)
//   dest       : destination captured at start
//   WB_en      : captured write-back enable, only while done is high
// ---------------------------------------------------------------------------
module exe_muldiv
   import exe_muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [3:0]       EXE_cmd,
   input  logic [WIDTH-1:0] Val1,
   input  logic [WIDTH-1:0] Val2,
   input  logic [4:0]       dest_in,
   input  logic             WB_en_in,
   output logic             freeze,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       dest,
   output logic             WB_en
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    counter_q, counter_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             isDiv_q, isDiv_d;
   logic [4:0]       dest_q, dest_d;
   logic             wbEn_q, wbEn_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             start;
   logic [WIDTH-1:0] stepOpA, stepOpB, stepAcc;

   muldiv_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .isDiv_i (isDiv_q),
      .opA_i   (opA_q),
      .opB_i   (opB_q),
      .acc_i   (acc_q),
      .opA_o   (stepOpA),
      .opB_o   (stepOpB),
      .acc_o   (stepAcc)
   );

   // A new operation may only begin from IDLE. Reset and flush both veto it,
   // and freeze is built from start so the pipeline stalls in the very cycle
   // the instruction first appears, keeping it parked in ID/EX while we run.
   always_comb begin
      start  = ~rst & ~flush & (state_q == IDLE) & isMulDivCmd(EXE_cmd);
      freeze = start | (~rst & (state_q == BUSY));
   end

   // Next-state logic. IDLE captures operands and tags; BUSY applies one step
   // per cycle and on the last step stores the finished value; DONE always
   // returns to IDLE so a command still sitting in ID/EX is not re-run.
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      opA_d     = opA_q;
      opB_d     = opB_q;
      acc_d     = acc_q;
      isDiv_d   = isDiv_q;
      dest_d    = dest_q;
      wbEn_d    = wbEn_q;
      result_d  = result_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               opA_d     = Val1;
               opB_d     = Val2;
               acc_d     = '0;
               isDiv_d   = (EXE_cmd == CMD_DIVU);
               dest_d    = dest_in;
               wbEn_d    = WB_en_in;
               counter_d = '0;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               opA_d     = stepOpA;
               opB_d     = stepOpB;
               acc_d     = stepAcc;
               counter_d = counter_q + CW'(1);
               if (counter_q == LAST_ITER) begin
                  result_d = isDiv_q ? stepOpA : stepAcc;
                  state_d  = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset clears everything, which also
   // abandons any operation in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         counter_q <= '0;
         opA_q     <= '0;
         opB_q     <= '0;
         acc_q     <= '0;
         isDiv_q   <= 1'b0;
         dest_q    <= '0;
         wbEn_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         opA_q     <= opA_d;
         opB_q     <= opB_d;
         acc_q     <= acc_d;
         isDiv_q   <= isDiv_d;
         dest_q    <= dest_d;
         wbEn_q    <= wbEn_d;
         result_q  <= result_d;
      end
   end

   // Result-side outputs. The write-back enable is gated by DONE so the
   // register file only sees it during the one-cycle done pulse.
   always_comb begin
      done   = (state_q == DONE);
      WB_en  = (state_q == DONE) & wbEn_q;
      result = result_q;
      dest   = dest_q;
   end

endmodule

// File: tb/tb_exe_muldiv.sv
// ---------------------------------------------------------------------------
// tb_exe_muldiv
// Directed self-checking bench for exe_muldiv with hand-computed results.
// Inputs change just after the falling edge; outputs are sampled 1 ns later,
// well away from the rising edge where the DUT updates.
// ---------------------------------------------------------------------------
module tb_exe_muldiv;
   import exe_muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic [3:0]   EXE_cmd;
   logic [W-1:0] Val1;
   logic [W-1:0] Val2;
   logic [4:0]   dest_in;
   logic         WB_en_in;
   logic         freeze;
   logic         done;
   logic [W-1:0] result;
   logic [4:0]   dest;
   logic         WB_en;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   exe_muldiv #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .EXE_cmd  (EXE_cmd),
      .Val1     (Val1),
      .Val2     (Val2),
      .dest_in  (dest_in),
      .WB_en_in (WB_en_in),
      .freeze   (freeze),
      .done     (done),
      .result   (result),
      .dest     (dest),
      .WB_en    (WB_en)
   );

   // Free-running clock and a cycle counter used to time done pulses.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Drives the ID/EX-side inputs for the current cycle.
   task automatic applyStimulus(input logic [3:0] cmd, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [4:0] d,
                                input logic wb, input logic fl);
      EXE_cmd  = cmd;
      Val1     = a;
      Val2     = b;
      dest_in  = d;
      WB_en_in = wb;
      flush    = fl;
   endtask

   // Issues one command, holds it (as a frozen ID/EX would) until done, and
   // checks latency, stall behaviour and the done-cycle outputs. Returns the
   // cycle number at which done was observed.
   task automatic runOp(input string tag, input logic [3:0] cmd,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] d, input logic wb,
                        input logic [W-1:0] expRes, output int doneCycle);
      int  lat;
      logic seen;
      logic freezeHeld;
      @(negedge clk);
      applyStimulus(cmd, a, b, d, wb, 1'b0);
      #1;
      checkOutput({tag, " start freeze"}, freeze, 1);
      lat        = 0;
      seen       = 1'b0;
      freezeHeld = 1'b1;
      while (!seen && lat < 100) begin
         @(negedge clk);
         #1;
         lat++;
         if (done) seen = 1'b1;
         else if (!freeze) freezeHeld = 1'b0;
      end
      doneCycle = cyc;
      checkOutput({tag, " latency"}, lat, W + 1);
      checkOutput({tag, " busy freeze"}, freezeHeld, 1);
      checkOutput({tag, " done freeze"}, freeze, 0);
      checkOutput({tag, " result"}, result, expRes);
      checkOutput({tag, " dest"}, dest, d);
      checkOutput({tag, " WB_en"}, WB_en, wb);
   endtask

   // The cycle after DONE: command removed, unit must be idle and quiet with
   // the last result still visible.
   task automatic idleCheck(input string tag, input logic [W-1:0] expRes);
      @(negedge clk);
      applyStimulus(CMD_ADD, '0, '0, '0, 1'b0, 1'b0);
      #1;
      checkOutput({tag, " idle done"}, done, 0);
      checkOutput({tag, " idle WB_en"}, WB_en, 0);
      checkOutput({tag, " idle freeze"}, freeze, 0);
      checkOutput({tag, " idle result hold"}, result, expRes);
   endtask

   // Runs a number of cycles and reports whether done ever pulsed.
   task automatic watchNoDone(input string tag, input int n);
      logic sawDone;
      sawDone = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         if (done) sawDone = 1'b1;
      end
      checkOutput({tag, " no done"}, sawDone, 0);
   endtask

   initial begin
      int dc1;
      int dc2;

      // Reset with a MUL already presented: nothing may stall or start.
      rst = 1'b1;
      applyStimulus(CMD_MUL, 32'd7, 32'd6, 5'd3, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("reset freeze", freeze, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset WB_en", WB_en, 0);
      checkOutput("reset result", result, 0);
      checkOutput("reset dest", dest, 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(CMD_ADD, '0, '0, '0, 1'b0, 1'b0);

      $display("[TB] basic MUL / DIVU vectors");
      runOp("mul 7x6", CMD_MUL, 32'd7, 32'd6, 5'd5, 1'b1, 32'd42, dc1);
      idleCheck("mul 7x6", 32'd42);
      runOp("mul ovf", CMD_MUL, 32'hFFFF_FFFF, 32'd2, 5'd31, 1'b0,
            32'hFFFF_FFFE, dc1);
      idleCheck("mul ovf", 32'hFFFF_FFFE);
      runOp("divu 100/7", CMD_DIVU, 32'd100, 32'd7, 5'd12, 1'b1, 32'd14, dc1);
      idleCheck("divu 100/7", 32'd14);
      runOp("divu 5/0", CMD_DIVU, 32'd5, 32'd0, 5'd7, 1'b1, 32'hFFFF_FFFF, dc1);
      idleCheck("divu 5/0", 32'hFFFF_FFFF);

      $display("[TB] flush in IDLE suppresses start");
      @(negedge clk);
      applyStimulus(CMD_MUL, 32'd3, 32'd3, 5'd4, 1'b1, 1'b1);
      #1;
      checkOutput("idle flush freeze", freeze, 0);
      @(negedge clk);
      applyStimulus(CMD_ADD, '0, '0, '0, 1'b0, 1'b0);
      #1;
      checkOutput("idle flush after freeze", freeze, 0);
      watchNoDone("idle flush", 40);

      $display("[TB] flush during BUSY");
      @(negedge clk);
      applyStimulus(CMD_MUL, 32'd3, 32'd3, 5'd4, 1'b1, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 10) flush = 1'b1;
         #1;
      end
      checkOutput("busy flush cycle freeze", freeze, 1);
      @(negedge clk);
      applyStimulus(CMD_ADD, '0, '0, '0, 1'b0, 1'b0);
      #1;
      checkOutput("busy flush after freeze", freeze, 0);
      checkOutput("busy flush after done", done, 0);
      watchNoDone("busy flush", 40);
      runOp("mul 3x3", CMD_MUL, 32'd3, 32'd3, 5'd4, 1'b1, 32'd9, dc1);
      idleCheck("mul 3x3", 32'd9);

      $display("[TB] reset during BUSY");
      @(negedge clk);
      applyStimulus(CMD_MUL, 32'd7, 32'd9, 5'd9, 1'b1, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 20) rst = 1'b1;
         #1;
      end
      checkOutput("busy rst freeze", freeze, 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(CMD_ADD, '0, '0, '0, 1'b0, 1'b0);
      #1;
      checkOutput("post rst done", done, 0);
      checkOutput("post rst WB_en", WB_en, 0);
      checkOutput("post rst result", result, 0);
      checkOutput("post rst dest", dest, 0);
      checkOutput("post rst freeze", freeze, 0);
      watchNoDone("post rst", 40);

      $display("[TB] back-to-back MUL then DIVU");
      runOp("b2b mul 2x5", CMD_MUL, 32'd2, 32'd5, 5'd1, 1'b1, 32'd10, dc1);
      runOp("b2b divu 9/3", CMD_DIVU, 32'd9, 32'd3, 5'd2, 1'b1, 32'd3, dc2);
      checkOutput("b2b done spacing", dc2 - dc1, W + 2);
      idleCheck("b2b", 32'd3);

      $display("[TB] ADD never stalls");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         applyStimulus(CMD_ADD, 32'(i + 1), 32'(i + 2), 5'(i), 1'b1, 1'b0);
         #1;
         checkOutput("add freeze", freeze, 0);
      end
      watchNoDone("add", 5);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
